// File: rtl/hub75_scan_sched.sv
// HUB75 refresh sequencer: row scan with binary-code-modulated bit planes, overlapping the
// column shift of the next (row, plane) with the display of the current one.
module hub75_scan_sched #(
    parameter int ROWS        = 32,
    parameter int PLANES      = 4,
    parameter int BASE_TICKS  = 64,
    parameter int BLANK_TICKS = 2,
    parameter int ROW_W       = $clog2(ROWS),
    parameter int PW          = (PLANES > 1) ? $clog2(PLANES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             shift_done,
    output logic             shift_start,
    output logic [ROW_W-1:0] shift_row,
    output logic [PW-1:0]    shift_plane,
    output logic [ROW_W-1:0] row_addr,
    output logic             LATCH,
    output logic             nOE,
    output logic             frame_done,
    output logic             busy
);
    localparam int TW = $clog2(BASE_TICKS << (PLANES - 1)) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_BLANK = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_SHOW  = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;

    logic [2:0]       state, state_nx;
    logic [TW-1:0]    timer;
    logic [PW-1:0]    disp_plane;
    logic             pending, ready, issued, first;
    logic             done_ok, tc, issue_now, last_slot;
    logic [ROW_W-1:0] nx_row;
    logic [PW-1:0]    nx_plane;

    always_comb begin
        // a done in the same cycle as our start cannot belong to that start
        done_ok   = shift_done && pending && !shift_start;
        tc        = (timer == '0);
        issue_now = first ? enable : issued;
        last_slot = (row_addr == ROW_W'(ROWS - 1)) && (disp_plane == PW'(PLANES - 1));
        nx_row    = shift_row;
        nx_plane  = shift_plane + PW'(1);
        if (shift_plane == PW'(PLANES - 1)) begin
            nx_plane = '0;
            nx_row   = (shift_row == ROW_W'(ROWS - 1)) ? '0 : shift_row + ROW_W'(1);
        end
        state_nx = state;
        case (state)
            S_IDLE:  if (enable) state_nx = S_FILL;
            S_FILL:  if (done_ok) state_nx = S_BLANK;
            S_BLANK: if (tc) state_nx = S_LATCH;
            S_LATCH: state_nx = S_SHOW;
            S_SHOW: begin
                if (tc) begin
                    if (ready || done_ok) state_nx = S_BLANK;
                    else if (issue_now)   state_nx = S_WAIT;
                    else                  state_nx = S_IDLE;
                end
            end
            S_WAIT:  if (done_ok) state_nx = S_BLANK;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            disp_plane  <= '0;
            pending     <= 1'b0;
            ready       <= 1'b0;
            issued      <= 1'b0;
            first       <= 1'b0;
            shift_start <= 1'b0;
            shift_row   <= '0;
            shift_plane <= '0;
            row_addr    <= '0;
            LATCH       <= 1'b0;
            nOE         <= 1'b1;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            busy        <= (state_nx != S_IDLE);
            nOE         <= (state_nx != S_SHOW);
            LATCH       <= (state_nx == S_LATCH);
            shift_start <= 1'b0;
            frame_done  <= 1'b0;
            first       <= (state == S_LATCH);
            if (done_ok) begin
                pending <= 1'b0;
                ready   <= 1'b1;
            end
            if (state == S_IDLE && enable) begin
                shift_row   <= '0;
                shift_plane <= '0;
                shift_start <= 1'b1;
                pending     <= 1'b1;
            end
            if (state == S_SHOW && first) begin
                ready       <= 1'b0;
                shift_row   <= nx_row;
                shift_plane <= nx_plane;
                issued      <= enable;
                if (enable) begin
                    shift_start <= 1'b1;
                    pending     <= 1'b1;
                end
            end
            if (state == S_SHOW && tc && last_slot) frame_done <= 1'b1;
            // row address moves with nOE already high, a full blank window ahead of LATCH
            if (state_nx == S_BLANK && state != S_BLANK) begin
                timer      <= TW'(BLANK_TICKS - 1);
                row_addr   <= shift_row;
                disp_plane <= shift_plane;
                ready      <= 1'b0;
            end else if (state == S_LATCH) begin
                timer <= (TW'(BASE_TICKS) << disp_plane) - TW'(1);
            end else if (!tc) begin
                timer <= timer - TW'(1);
            end
        end
    end
endmodule
